// File: rtl/main_fsm_if.sv
// main_fsm_if: opcode in, datapath enables/selects and state trace out
interface main_fsm_if;
  logic [6:0] op;
  logic [1:0] alu_op;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] result_src;
  logic       adr_src;
  logic       ir_write;
  logic       pc_update;
  logic       branch;
  logic       reg_write;
  logic       mem_write;
  logic       illegal_op;
  logic [3:0] state;
  modport slave (
    input  op,
    output alu_op, alu_src_a, alu_src_b, result_src, adr_src, ir_write,
           pc_update, branch, reg_write, mem_write, illegal_op, state
  );
  modport master (
    output op,
    input  alu_op, alu_src_a, alu_src_b, result_src, adr_src, ir_write,
           pc_update, branch, reg_write, mem_write, illegal_op, state
  );
endinterface

// File: rtl/main_fsm.sv
// main_fsm: Moore control sequencer for the multi-cycle RV32I core
module main_fsm (
  input  logic             clk,
  input  logic             reset,
  main_fsm_if.slave        bus
);
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10
  } state_t;
  state_t state_q, state_d;
  always_ff @(posedge clk or posedge reset)
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  always_comb begin
    state_d        = FETCH;
    bus.alu_op     = 2'b00;
    bus.alu_src_a  = 2'b00;
    bus.alu_src_b  = 2'b00;
    bus.result_src = 2'b00;
    bus.adr_src    = 1'b0;
    bus.ir_write   = 1'b0;
    bus.pc_update  = 1'b0;
    bus.branch     = 1'b0;
    bus.reg_write  = 1'b0;
    bus.mem_write  = 1'b0;
    bus.illegal_op = 1'b0;
    case (state_q)
      FETCH: begin
        bus.alu_src_b  = 2'b10;
        bus.result_src = 2'b10;
        bus.ir_write   = 1'b1;
        bus.pc_update  = 1'b1;
        state_d        = DECODE;
      end
      DECODE: begin
        bus.alu_src_a  = 2'b01;
        bus.alu_src_b  = 2'b01;
        state_d        = (bus.op == OP_LW || bus.op == OP_SW) ? MEMADR   :
                         (bus.op == OP_R)                     ? EXECUTER :
                         (bus.op == OP_I)                     ? EXECUTEI :
                         (bus.op == OP_BEQ)                   ? BEQ      :
                         (bus.op == OP_JAL)                   ? JAL      : FETCH;
        bus.illegal_op = (state_d == FETCH);
      end
      MEMADR: begin
        bus.alu_src_a  = 2'b10;
        bus.alu_src_b  = 2'b01;
        state_d        = (bus.op == OP_LW) ? MEMREAD  :
                         (bus.op == OP_SW) ? MEMWRITE : FETCH;
      end
      MEMREAD: begin
        bus.adr_src    = 1'b1;
        state_d        = MEMWB;
      end
      MEMWB: begin
        bus.result_src = 2'b01;
        bus.reg_write  = 1'b1;
      end
      MEMWRITE: begin
        bus.adr_src    = 1'b1;
        bus.mem_write  = 1'b1;
      end
      EXECUTER: begin
        bus.alu_src_a  = 2'b10;
        bus.alu_op     = 2'b10;
        state_d        = ALUWB;
      end
      EXECUTEI: begin
        bus.alu_src_a  = 2'b10;
        bus.alu_src_b  = 2'b01;
        bus.alu_op     = 2'b10;
        state_d        = ALUWB;
      end
      ALUWB: bus.reg_write = 1'b1;
      BEQ: begin
        bus.alu_src_a  = 2'b10;
        bus.alu_op     = 2'b01;
        bus.branch     = 1'b1;
      end
      JAL: begin
        bus.alu_src_a  = 2'b01;
        bus.alu_src_b  = 2'b10;
        bus.pc_update  = 1'b1;
        state_d        = ALUWB;
      end
      default: ;
    endcase
    // No side-effecting enable may leak out while reset is held
    if (reset) begin
      bus.ir_write   = 1'b0;
      bus.pc_update  = 1'b0;
      bus.branch     = 1'b0;
      bus.reg_write  = 1'b0;
      bus.mem_write  = 1'b0;
      bus.illegal_op = 1'b0;
    end
  end
  assign bus.state = state_q;
endmodule

// File: tb/tb_main_fsm.sv
// tb_main_fsm: randomized instruction streams checked against a cycle-table model
module tb_main_fsm;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  logic [3:0] exp_q[$];
  main_fsm_if bus();
  main_fsm dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                         IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;
  wire [14:0] act = {bus.alu_op, bus.alu_src_a, bus.alu_src_b, bus.result_src, bus.adr_src,
                     bus.ir_write, bus.pc_update, bus.branch, bus.reg_write, bus.mem_write,
                     bus.illegal_op};
  function automatic void exp_seq(input logic [6:0] o);
    exp_q = {};
    case (o)
      LW:      exp_q = {4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
      SW:      exp_q = {4'd0, 4'd1, 4'd2, 4'd5};
      RT:      exp_q = {4'd0, 4'd1, 4'd6, 4'd8};
      IT:      exp_q = {4'd0, 4'd1, 4'd7, 4'd8};
      BQ:      exp_q = {4'd0, 4'd1, 4'd9};
      JL:      exp_q = {4'd0, 4'd1, 4'd10, 4'd8};
      default: exp_q = {4'd0, 4'd1};
    endcase
  endfunction
  function automatic logic [14:0] exp_out(input logic [3:0] s, input logic [6:0] o, input logic r);
    logic [1:0] aop = 0, a = 0, b = 0, rs = 0;
    logic adr = 0, ir = 0, pc = 0, br = 0, rw = 0, mw = 0, il = 0;
    case (s)
      4'd0:  begin b = 2; rs = 2; ir = 1; pc = 1; end
      4'd1:  begin a = 1; b = 1; il = !(o inside {LW, SW, RT, IT, BQ, JL}); end
      4'd2:  begin a = 2; b = 1; end
      4'd3:  adr = 1;
      4'd4:  begin rs = 1; rw = 1; end
      4'd5:  begin adr = 1; mw = 1; end
      4'd6:  begin a = 2; aop = 2; end
      4'd7:  begin a = 2; b = 1; aop = 2; end
      4'd8:  rw = 1;
      4'd9:  begin a = 2; aop = 1; br = 1; end
      4'd10: begin a = 1; b = 2; pc = 1; end
      default: ;
    endcase
    if (r) {ir, pc, br, rw, mw, il} = 6'b0;
    return {aop, a, b, rs, adr, ir, pc, br, rw, mw, il};
  endfunction
  task automatic check_cycle(input string name, input logic [3:0] s);
    logic [14:0] e = exp_out(s, bus.op, reset);
    n_cmp += 2;
    if (bus.state !== s) begin
      n_bad++;
      $display("FAIL %s state: got %0d want %0d", name, bus.state, s);
    end
    if (act !== e) begin
      n_bad++;
      $display("FAIL %s outputs (state %0d): got %b want %b", name, s, act, e);
    end
  endtask
  task automatic run_instr(input string name, input logic [6:0] o);
    bus.op = o;
    exp_seq(o);
    foreach (exp_q[i]) begin
      check_cycle(name, exp_q[i]);
      @(posedge clk); #1;
    end
  endtask
  task automatic test_reset;
    bus.op = 7'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check_cycle("reset_hold", 4'd0);
    end
    @(negedge clk); reset = 1'b0; #1;
    check_cycle("reset_release", 4'd0);
    n_cmp++;
    if ({bus.ir_write, bus.pc_update, bus.alu_src_b, bus.result_src} !== 6'b11_10_10) begin
      n_bad++;
      $display("FAIL first_fetch: got %b want 111010", {bus.ir_write, bus.pc_update, bus.alu_src_b, bus.result_src});
    end
    @(posedge clk); #1;
    check_cycle("first_decode", 4'd1);
    @(posedge clk); #1;
  endtask
  task automatic test_each_op;
    run_instr("lw", LW);
    run_instr("sw", SW);
    run_instr("rtype", RT);
    run_instr("itype", IT);
    run_instr("beq", BQ);
    run_instr("jal", JL);
    run_instr("illegal", 7'b0110111);
  endtask
  task automatic test_random;
    logic [6:0] ops[6] = '{LW, SW, RT, IT, BQ, JL};
    for (int k = 0; k < 40; k++)
      run_instr("rand", ($urandom_range(1) == 1) ? ops[$urandom_range(5)] : 7'($urandom));
    check_cycle("rand_end", 4'd0);
  endtask
  task automatic test_reset_abort;
    bus.op = LW;
    check_cycle("abort_pre", 4'd0);
    repeat (3) begin @(posedge clk); #1; end
    check_cycle("abort_memread", 4'd3);
    reset = 1'b1; #1;
    check_cycle("abort_async", 4'd0);
    @(posedge clk); #1;
    check_cycle("abort_held", 4'd0);
    @(negedge clk); reset = 1'b0; #1;
    check_cycle("abort_release", 4'd0);
    @(posedge clk); #1;
    check_cycle("abort_restart", 4'd1);
    repeat (4) begin @(posedge clk); #1; end
    run_instr("post_abort_lw", LW);
  endtask
  initial begin
    test_reset;
    test_each_op;
    test_random;
    test_reset_abort;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/main_fsm.md
Name: main_fsm

Overview:
Moore control state machine for the multi-cycle RV32I core. It sequences each instruction through fetch, decode, execute, memory and writeback cycles. It drives the datapath enables and mux selects, and produces the 2-bit alu_op consumed by the ALU decoder alongside funct3/op[5]/funct7[5]. It sits inside the control unit, directly upstream of the ALU decoder.

Parameters:
None (state encoding fixed, 4 bits).

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-high reset
op  input  7  opcode field of instruction register (instr[6:0]), stable from DECODE onward
alu_op  output  2  00 add, 01 subtract/compare (branch), 10 funct-decoded; to ALU decoder
alu_src_a  output  2  00 PC, 01 OldPC, 10 rs1 data
alu_src_b  output  2  00 rs2 data, 01 ImmExt, 10 constant 4
result_src  output  2  00 ALUOut, 01 Data, 10 ALUResult
adr_src  output  1  0 PC, 1 Result (memory address select)
ir_write  output  1  instruction register load enable
pc_update  output  1  unconditional PC write enable
branch  output  1  conditional PC write (combined with Zero outside)
reg_write  output  1  register file write enable
mem_write  output  1  data memory write enable
illegal_op  output  1  high during DECODE when op is unsupported
state  output  4  current state code, for debug/trace

Behaviour:
- State register updates on rising clk. reset high asynchronously forces FETCH; state remains FETCH until the first rising edge after reset deasserts.
- Codes: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BEQ 9, JAL 10. Codes 11-15 are unreachable; if entered, all outputs are 0 and next state is FETCH.
- Outputs are purely a function of state, except illegal_op (state and op). Any output not listed for a state is 0.
- Reset gating: while reset is high, ir_write, pc_update, reg_write, mem_write, branch and illegal_op are forced to 0. Mux selects and alu_op show FETCH values.
- FETCH: adr_src=0, ir_write=1, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10, pc_update=1. Next state: DECODE.
- DECODE: alu_src_a=01, alu_src_b=01, alu_op=00 (branch target precompute). Next state by op:
  - 0000011 (lw) or 0100011 (sw) -> MEMADR
  - 0110011 -> EXECUTER
  - 0010011 -> EXECUTEI
  - 1100011 -> BEQ
  - 1101111 -> JAL
  - any other op -> FETCH, with illegal_op=1 for that cycle
- MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00. Next: MEMREAD if op=0000011, MEMWRITE if op=0100011, otherwise FETCH.
- MEMREAD: result_src=00, adr_src=1. Next: MEMWB.
- MEMWB: result_src=01, reg_write=1. Next: FETCH.
- MEMWRITE: result_src=00, adr_src=1, mem_write=1. Next: FETCH.
- EXECUTER: alu_src_a=10, alu_src_b=00, alu_op=10. Next: ALUWB.
- EXECUTEI: alu_src_a=10, alu_src_b=01, alu_op=10. Next: ALUWB.
- ALUWB: result_src=00, reg_write=1. Next: FETCH.
- BEQ: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, branch=1. Next: FETCH.
- JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_update=1. Next: ALUWB (writes PC+4 to rd).
- Cycle counts per instruction, FETCH inclusive: lw 5, sw 4, R-type 4, I-type ALU 4, beq 3, jal 4, illegal 2.
- alu_op=11 is never driven.
- Reset mid-instruction aborts immediately. No write enable is asserted during reset or on the release edge, and execution restarts at FETCH.

Test Plan:
- Hold reset 3 cycles then release: state=0 throughout, all write enables 0 during reset; first cycle after release shows ir_write=1, pc_update=1, alu_src_b=10, result_src=10.
- op=0000011: state sequence 0,1,2,3,4,0; reg_write=1 only in state 4 with result_src=01; adr_src=1 in state 3.
- op=0100011: sequence 0,1,2,5,0; mem_write=1 only in state 5; reg_write never asserted.
- op=0110011 then op=0010011: sequences 0,1,6,8,0 and 0,1,7,8,0; alu_op=10 in state 6/7 with alu_src_b=00 and 01 respectively.
- op=1100011: sequence 0,1,9,0 with branch=1, alu_op=01 in state 9. op=1101111: sequence 0,1,10,8,0 with pc_update=1 in 10, reg_write=1 in 8.
- op=0110111 (unsupported): illegal_op=1 in state 1, next state 0. Separately, assert reset during state 3 of lw: state=0 immediately, and no reg_write pulse occurs.
